// File: rtl/timer_sched.sv
// timer_sched: shares one timer among N_REQ hardware requesters.
//
// This block is the only bus master on the timer's register port. It arbitrates
// the pending requests and programs the timer for a one-shot delay on behalf of
// the winner. It then waits for the timer irq, acknowledges it, and pulses done
// to the winner. If the owner drops its request while the timer runs, the timer
// is stopped and the irq is cleared, and no done pulse is given.
//
// Ports
//   clk        clock
//   reset      asynchronous reset, active low
//   req        level request per requester, held until done or cancelled
//   delay      per-requester delay in clk cycles, slice n = [32n+31:32n]
//   done       one-cycle completion pulse to the owner
//   busy       timer owned (FSM not idle)
//   owner      index of the current owner, valid while busy
//   t_cs_      timer chip select, active low
//   t_as_      timer address strobe, active low
//   t_rw       timer read (1) / write (0)
//   t_addr     timer register address
//   t_wr_data  timer write data
//   t_rd_data  timer read data (unused, reserved for status reads)
//   t_rdy_     timer ready, active low
//   t_irq      timer expiry interrupt
//
// Configuration
//   TIMER_SCHED_FIXED_PRIO_EN  defined: fixed priority, lowest index wins, no
//                              round-robin pointer. Undefined: round-robin.
//
// Each register write takes two states: *_S drives both strobes low for one
// cycle, and *_W holds the strobes high until the timer reports ready.

module timer_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*32-1:0]   delay,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic [ID_W-1:0]       owner,
  output logic                  t_cs_,
  output logic                  t_as_,
  output logic                  t_rw,
  output logic [1:0]            t_addr,
  output logic [31:0]           t_wr_data,
  input  logic [31:0]           t_rd_data,
  input  logic                  t_rdy_,
  input  logic                  t_irq
);

  localparam logic        StrobeOn  = 1'b0;
  localparam logic        StrobeOff = 1'b1;
  localparam logic        BusRead   = 1'b1;
  localparam logic        BusWrite  = 1'b0;

  localparam logic [1:0]  AddrCtrl    = 2'd0;
  localparam logic [1:0]  AddrIntr    = 2'd1;
  localparam logic [1:0]  AddrExpr    = 2'd2;
  localparam logic [1:0]  AddrCounter = 2'd3;

  // Control word: bit1 = mode (0 = one-shot), bit0 = start.
  localparam logic [31:0] CtrlOneShotStart = 32'h0000_0001;

  typedef enum logic [3:0] {
    StIdle,
    StExprS, StExprW,
    StCntS,  StCntW,
    StCtlS,  StCtlW,
    StRun,
    StStopS, StStopW,
    StIclrS, StIclrW
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [31:0]     delay_q, delay_d;
  logic            cancel_q, cancel_d;
  logic [ID_W-1:0] grant;
  logic [31:0]     delay_arr [N_REQ];

  logic unused_rd;
  assign unused_rd = ^t_rd_data;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      delay_arr[i] = delay[32*i +: 32];
    end
  end

`ifdef TIMER_SCHED_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req[ID_W'(k)]) begin
        found = 1'b1;
        grant = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_q, rr_d;

  // Scan from the rr pointer upwards, wrapping at N_REQ.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(rr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      delay_q  <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      delay_q  <= delay_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    delay_d   = delay_q;
    cancel_d  = cancel_q;
`ifndef TIMER_SCHED_FIXED_PRIO_EN
    rr_d      = rr_q;
`endif
    done      = '0;
    t_cs_     = StrobeOff;
    t_as_     = StrobeOff;
    t_rw      = BusRead;
    t_addr    = '0;
    t_wr_data = '0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d  = grant;
          delay_d  = delay_arr[grant];
          cancel_d = 1'b0;
          state_d  = StExprS;
        end
      end
      StExprS, StExprW: begin
        t_rw      = BusWrite;
        t_addr    = AddrExpr;
        t_wr_data = delay_q;
        if (state_q == StExprS) begin
          t_cs_   = StrobeOn;
          t_as_   = StrobeOn;
          state_d = StExprW;
        end else if (t_rdy_ == StrobeOn) begin
          state_d = StCntS;
        end
      end
      StCntS, StCntW: begin
        t_rw   = BusWrite;
        t_addr = AddrCounter;
        if (state_q == StCntS) begin
          t_cs_   = StrobeOn;
          t_as_   = StrobeOn;
          state_d = StCntW;
        end else if (t_rdy_ == StrobeOn) begin
          state_d = StCtlS;
        end
      end
      StCtlS, StCtlW: begin
        t_rw      = BusWrite;
        t_addr    = AddrCtrl;
        t_wr_data = CtrlOneShotStart;
        if (state_q == StCtlS) begin
          t_cs_   = StrobeOn;
          t_as_   = StrobeOn;
          state_d = StCtlW;
        end else if (t_rdy_ == StrobeOn) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Expiry takes precedence over a request dropped in the same cycle.
        if (t_irq) begin
          state_d = StIclrS;
        end else if (!req[owner_q]) begin
          cancel_d = 1'b1;
          state_d  = StStopS;
        end
      end
      StStopS, StStopW: begin
        t_rw   = BusWrite;
        t_addr = AddrCtrl;
        if (state_q == StStopS) begin
          t_cs_   = StrobeOn;
          t_as_   = StrobeOn;
          state_d = StStopW;
        end else if (t_rdy_ == StrobeOn) begin
          state_d = StIclrS;
        end
      end
      StIclrS, StIclrW: begin
        t_rw   = BusWrite;
        t_addr = AddrIntr;
        if (state_q == StIclrS) begin
          t_cs_   = StrobeOn;
          t_as_   = StrobeOn;
          state_d = StIclrW;
        end else if (t_rdy_ == StrobeOn) begin
          if (!cancel_q) begin
            done[owner_q] = 1'b1;
          end
`ifndef TIMER_SCHED_FIXED_PRIO_EN
          rr_d = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign owner = owner_q;

endmodule
